// File: rtl/nn_pkg.sv
// Shared types, default widths and saturation helper for the neuron accumulator.
package nn_pkg;

    typedef enum logic [1:0] {
        IDLE_ACC = 2'd0,
        DRAIN    = 2'd1,
        BIAS     = 2'd2,
        DONE     = 2'd3
    } acc_state_t;

    localparam int NN_DATA_W  = 8;
    localparam int NN_VEC_LEN = 8;
    localparam int NN_ACC_W   = 19;
    localparam int NN_OUT_W   = 16;

    // Clamp a sign-extended value to the signed range of an out_w-bit result.
    function automatic logic signed [63:0] sat_signed(input logic signed [63:0] value,
                                                      input int unsigned        out_w);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (out_w - 1)) - 64'sd1;
        lo = -hi - 64'sd1;
        if (value > hi) begin
            return hi;
        end else if (value < lo) begin
            return lo;
        end
        return value;
    endfunction

endpackage

// File: rtl/signed_mac_stage.sv
// Product register, product-valid flag and accumulator with zero/clear controls.
module signed_mac_stage #(
    parameter int DATA_W = 8,
    parameter int ACC_W  = 19
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     clear_i,
    input  logic                     load_i,
    input  logic signed [DATA_W-1:0] data_i,
    input  logic signed [DATA_W-1:0] weight_i,
    input  logic                     acc_zero_i,
    output logic signed [ACC_W-1:0]  acc_o
);

    logic signed [2*DATA_W-1:0] prod_q, prod_d;
    logic                       prod_v_q, prod_v_d;
    logic signed [ACC_W-1:0]    acc_q, acc_d;

    // prod_v follows load each cycle, so every product is folded in exactly once.
    always_comb begin
        prod_d   = prod_q;
        prod_v_d = load_i;
        acc_d    = acc_q;
        if (load_i) begin
            prod_d = data_i * weight_i;
        end
        if (prod_v_q) begin
            acc_d = acc_q + ACC_W'(prod_q);
        end
        if (acc_zero_i) begin
            acc_d = '0;
        end
        if (clear_i) begin
            prod_d   = '0;
            prod_v_d = 1'b0;
            acc_d    = '0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            prod_q   <= '0;
            prod_v_q <= 1'b0;
            acc_q    <= '0;
        end else begin
            prod_q   <= prod_d;
            prod_v_q <= prod_v_d;
            acc_q    <= acc_d;
        end
    end

    assign acc_o = acc_q;

endmodule

// File: rtl/neuron_accumulator.sv
// Vector MAC neuron: accumulate, add bias, optional ReLU, saturate, valid/ready out.
// Build option: NEURON_RELU_EN enables ReLU and the element_index range check.
module neuron_accumulator
    import nn_pkg::*;
#(
    parameter int DATA_W  = NN_DATA_W,
    parameter int VEC_LEN = NN_VEC_LEN,
    parameter int ACC_W   = NN_ACC_W,
    parameter int OUT_W   = NN_OUT_W
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     clear,
    input  logic                     en,
    input  logic [3:0]               element_index,
    input  logic                     new_vector,
    input  logic signed [DATA_W-1:0] data_in,
    input  logic signed [DATA_W-1:0] weight_in,
    input  logic signed [DATA_W-1:0] bias_in,
    output logic                     busy,
    output logic signed [OUT_W-1:0]  result,
    output logic                     result_valid,
    input  logic                     result_ready
);

    localparam int SUM_W = ACC_W + 1;

    acc_state_t               state_q, state_d;
    logic signed [OUT_W-1:0]  result_q, result_d;
    logic                     result_valid_q, result_valid_d;
    logic                     busy_q, busy_d;

    logic                     load;
    logic                     acc_zero;
    logic signed [ACC_W-1:0]  acc;
    logic signed [SUM_W-1:0]  sum;
    logic signed [SUM_W-1:0]  sum_act;
    logic signed [63:0]       sat_wide;

    // Elements are only taken while idle; en during busy or on the marker is dropped.
    assign load     = en && !new_vector && (state_q == IDLE_ACC) && !clear;
    assign acc_zero = (state_q == BIAS);

    signed_mac_stage #(
        .DATA_W (DATA_W),
        .ACC_W  (ACC_W)
    ) u_mac (
        .clk_i      (clock),
        .rst_i      (reset),
        .clear_i    (clear),
        .load_i     (load),
        .data_i     (data_in),
        .weight_i   (weight_in),
        .acc_zero_i (acc_zero),
        .acc_o      (acc)
    );

    always_comb begin
        sum     = SUM_W'(acc) + SUM_W'(bias_in);
        sum_act = sum;
`ifdef NEURON_RELU_EN
        if (sum[SUM_W-1]) begin
            sum_act = '0;
        end
`endif
        sat_wide = sat_signed(64'(sum_act), OUT_W);
    end

    always_comb begin
        state_d  = state_q;
        result_d = result_q;
        case (state_q)
            IDLE_ACC: if (new_vector) state_d = DRAIN;
            DRAIN:    state_d = BIAS;
            BIAS: begin
                result_d = sat_wide[OUT_W-1:0];
                state_d  = DONE;
            end
            DONE:     if (result_ready) state_d = IDLE_ACC;
            default:  state_d = IDLE_ACC;
        endcase
        if (clear) begin
            state_d = IDLE_ACC;
        end
        result_valid_d = (state_d == DONE);
        busy_d         = (state_d != IDLE_ACC);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q        <= IDLE_ACC;
            result_q       <= '0;
            result_valid_q <= 1'b0;
            busy_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            result_q       <= result_d;
            result_valid_q <= result_valid_d;
            busy_q         <= busy_d;
        end
    end

    assign result       = result_q;
    assign result_valid = result_valid_q;
    assign busy         = busy_q;

`ifdef NEURON_RELU_EN
    a_index_in_range : assert property (@(posedge clock) disable iff (reset)
        (en && !new_vector && state_q == IDLE_ACC) |-> (element_index < 4'(VEC_LEN)));
`else
    logic unused_idx;
    assign unused_idx = ^{element_index, 4'(VEC_LEN)};
`endif

endmodule
